apu_ram_arbiter: RTL and testbench

Shares the single APU-side port of the 64 KiB SPC700 RAM between two requesters: the DSP (read-only, sample/BRR fetch) and the SPC700 CPU core (read/write). It sits between the requesters and the RAM's `in_apu_*`/`out_apu_data` port; the control-side port stays dedicated to the UART command processor. The DSP has fixed priority, bounded by a starvation guard that guarantees the CPU a slot after a configurable run of DSP grants.

---
 rtl/apu_ram_pkg.sv | 23 ++
 rtl/apu_ram_arbiter.sv | 142 ++++++++++++++
 tb/tb_apu_ram_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/apu_ram_pkg.sv
// Shared types and widths for the APU RAM port arbiter.
// Holds the FSM state encoding, the owner encoding seen on the debug port, and the default widths.
package apu_ram_pkg;

  localparam int unsigned APU_ADDR_W = 16;
  localparam int unsigned APU_DATA_W = 8;
  localparam int unsigned STARVE_W   = 4;
  localparam int unsigned OWNER_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } arb_state_e;

  typedef enum logic [OWNER_W-1:0] {
    OWN_NONE = 2'd0,
    OWN_DSP  = 2'd1,
    OWN_CPU  = 2'd2
  } arb_owner_e;

endpackage

// File: rtl/apu_ram_arbiter.sv
// Arbitrates the single APU-side RAM port between the DSP (read-only) and the SPC700 CPU.
// The DSP has fixed priority, and a starvation guard gives the CPU a slot after STARVE_LIMIT DSP grants.
module apu_ram_arbiter
  import apu_ram_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = APU_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dsp_req,
  input  logic [ADDR_W-1:0]     dsp_address,
  output logic                  dsp_ack,
  output logic [APU_DATA_W-1:0] dsp_rdata,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_W-1:0]     cpu_address,
  input  logic [APU_DATA_W-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [APU_DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [APU_DATA_W-1:0] ram_data_in,
  output logic                  ram_we,
  input  logic [APU_DATA_W-1:0] ram_data_out,
  output logic [OWNER_W-1:0]    owner
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_e              state_q;
  arb_owner_e              owner_q;
  logic                    we_q;
  logic [STARVE_W-1:0]     starve_q;
  logic [STARVE_W-1:0]     starve_d;
  logic [ADDR_W-1:0]       ram_address_q;
  logic [APU_DATA_W-1:0]   ram_data_in_q;
  logic                    ram_we_q;
  logic                    dsp_ack_q;
  logic                    cpu_ack_q;
  logic [APU_DATA_W-1:0]   dsp_rdata_q;
  logic [APU_DATA_W-1:0]   cpu_rdata_q;
  logic                    grant_dsp;
  logic                    grant_cpu;

  // Grant decision in IDLE: a starved CPU beats the DSP, otherwise the DSP wins.
  always_comb begin
    grant_dsp = 1'b0;
    grant_cpu = 1'b0;
    starve_d  = starve_q;
    if (state_q == ST_IDLE) begin
      if (cpu_req && (starve_q == STARVE_MAX)) begin
        grant_cpu = 1'b1;
      end else if (dsp_req) begin
        grant_dsp = 1'b1;
      end else if (cpu_req) begin
        grant_cpu = 1'b1;
      end
    end
    if (grant_cpu) begin
      starve_d = '0;
    end else if (grant_dsp) begin
      if (!cpu_req) begin
        starve_d = '0;
      end else if (starve_q != STARVE_MAX) begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end
  end

  // Transaction FSM; the RAM address and write strobe are registered at the accept edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_NONE;
      we_q          <= 1'b0;
      starve_q      <= '0;
      ram_address_q <= '0;
      ram_data_in_q <= '0;
      ram_we_q      <= 1'b0;
      dsp_ack_q     <= 1'b0;
      cpu_ack_q     <= 1'b0;
      dsp_rdata_q   <= '0;
      cpu_rdata_q   <= '0;
    end else begin
      starve_q  <= starve_d;
      ram_we_q  <= 1'b0;
      dsp_ack_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_dsp) begin
            owner_q       <= OWN_DSP;
            we_q          <= 1'b0;
            ram_address_q <= dsp_address;
            ram_data_in_q <= '0;
            state_q       <= ST_ISSUE;
          end else if (grant_cpu) begin
            owner_q       <= OWN_CPU;
            we_q          <= cpu_we;
            ram_address_q <= cpu_address;
            ram_data_in_q <= cpu_wdata;
            ram_we_q      <= cpu_we;
            state_q       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (owner_q == OWN_DSP) begin
            dsp_rdata_q <= ram_data_out;
            dsp_ack_q   <= 1'b1;
          end else if (owner_q == OWN_CPU) begin
            if (!we_q) begin
              cpu_rdata_q <= ram_data_out;
            end
            cpu_ack_q <= 1'b1;
          end
          state_q <= ST_ACK;
        end
        ST_ACK: begin
          owner_q <= OWN_NONE;
          state_q <= ST_IDLE;
        end
        default: begin
          owner_q <= OWN_NONE;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign dsp_ack     = dsp_ack_q;
  assign dsp_rdata   = dsp_rdata_q;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign ram_address = ram_address_q;
  assign ram_data_in = ram_data_in_q;
  assign ram_we      = ram_we_q;
  assign owner       = owner_q;

endmodule

// File: tb/tb_apu_ram_arbiter.sv
// Scoreboard bench for apu_ram_arbiter with a behavioural 64 KiB synchronous RAM.
module tb_apu_ram_arbiter;

  logic        clock;
  logic        reset;
  logic        dsp_req;
  logic [15:0] dsp_address;
  logic        dsp_ack;
  logic [7:0]  dsp_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [15:0] ram_address;
  logic [7:0]  ram_data_in;
  logic        ram_we;
  logic [7:0]  ram_data_out;
  logic [1:0]  owner;

  typedef struct {
    logic       is_cpu;
    logic [7:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mem [0:65535];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  apu_ram_arbiter #(.STARVE_LIMIT(4), .ADDR_W(16)) dut (
    .clock(clock), .reset(reset),
    .dsp_req(dsp_req), .dsp_address(dsp_address), .dsp_ack(dsp_ack), .dsp_rdata(dsp_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_we(ram_we),
    .ram_data_out(ram_data_out), .owner(owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (ram_we) mem[ram_address] <= ram_data_in;
    ram_data_out <= mem[ram_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack pops the next expected transaction
  always @(negedge clock) begin
    if (!reset && (dsp_ack || cpu_ack)) begin
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack: dsp_ack=%0b cpu_ack=%0b with empty queue", dsp_ack, cpu_ack);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ack_owner", {30'd0, cpu_ack, dsp_ack}, e.is_cpu ? 32'd2 : 32'd1);
        chk(e.is_cpu ? "cpu_rdata" : "dsp_rdata", {24'd0, e.is_cpu ? cpu_rdata : dsp_rdata},
            {24'd0, e.data});
      end
    end
  end

  task automatic txn(input bit is_cpu, input bit we, input logic [15:0] addr,
                     input logic [7:0] wdata, input logic [7:0] exp_rd);
    int n;
    int we_cnt;
    bit got;
    exp_t e;
    n = 0; we_cnt = 0; got = 1'b0;
    @(negedge clock);
    e.is_cpu = is_cpu; e.data = exp_rd;
    exp_q.push_back(e);
    if (is_cpu) begin
      cpu_req = 1'b1; cpu_we = we; cpu_address = addr; cpu_wdata = wdata;
    end else begin
      dsp_req = 1'b1; dsp_address = addr;
    end
    while (!got && n < 10) begin
      @(negedge clock);
      n++;
      if (n == 1) chk("ram_address", {16'd0, ram_address}, {16'd0, addr});
      if (n <= 3) chk("owner", {30'd0, owner}, is_cpu ? 32'd2 : 32'd1);
      if (ram_we) we_cnt++;
      if (is_cpu ? cpu_ack : dsp_ack) got = 1'b1;
    end
    dsp_req = 1'b0;
    cpu_req = 1'b0;
    chk("ack_latency", n, 3);
    chk("ram_we_cycles", we_cnt, {31'd0, we});
  endtask

  initial begin
    int acks;
    int last;
    int n;
    exp_t e;
    bit [9:0] order;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1234] = 8'hA5;
    mem[16'h0100] = 8'h11;
    mem[16'h2000] = 8'h6E;
    mem[16'h3000] = 8'hC3;
    mem[16'h0000] = 8'h10;
    mem[16'h0001] = 8'h21;
    mem[16'h0002] = 8'h32;
    mem[16'h0003] = 8'h43;

    reset = 1'b1;
    dsp_req = 1'b0; dsp_address = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_address = '0; cpu_wdata = '0;
    repeat (3) @(negedge clock);
    chk("reset_outputs", {ram_address, ram_data_in, ram_we, dsp_ack, cpu_ack, owner, 3'd0},
        32'd0);
    chk("reset_rdata", {16'd0, dsp_rdata, cpu_rdata}, 32'd0);
    reset = 1'b0;

    // Single DSP read
    txn(1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5);

    // CPU write then read back; the write leaves cpu_rdata at its reset value
    txn(1'b1, 1'b1, 16'h00F0, 8'h5A, 8'h00);
    chk("mem_written", {24'd0, mem[16'h00F0]}, 32'h5A);
    txn(1'b1, 1'b0, 16'h00F0, 8'h00, 8'h5A);

    // CPU back-to-back reads holding req, address advanced at each ack
    @(negedge clock);
    e.is_cpu = 1'b1; e.data = 8'h10; exp_q.push_back(e);
    e.data = 8'h21; exp_q.push_back(e);
    e.data = 8'h32; exp_q.push_back(e);
    e.data = 8'h43; exp_q.push_back(e);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 16'h0000;
    acks = 0; last = 0; n = 0;
    while (acks < 4 && n < 40) begin
      @(negedge clock);
      n++;
      if (cpu_ack) begin
        if (acks > 0) chk("b2b_spacing", cyc - last, 4);
        last = cyc;
        acks++;
        if (acks < 4) cpu_address = 16'(acks);
        else cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    chk("b2b_acks", acks, 4);

    // Both requesters held: DSP x4, CPU, repeating (bit set = CPU)
    @(negedge clock);
    order = 10'b1000010000;
    for (int i = 0; i < 10; i++) begin
      e.is_cpu = order[i];
      e.data = order[i] ? 8'hC3 : 8'h6E;
      exp_q.push_back(e);
    end
    dsp_req = 1'b1; dsp_address = 16'h2000;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 16'h3000;
    acks = 0; n = 0;
    while (acks < 10 && n < 80) begin
      @(negedge clock);
      n++;
      if (dsp_ack || cpu_ack) begin
        acks++;
        if (acks == 10) begin
          dsp_req = 1'b0; cpu_req = 1'b0;
        end
      end
    end
    dsp_req = 1'b0; cpu_req = 1'b0;
    chk("starve_acks", acks, 10);

    // Reset in ISSUE of a CPU write aborts it
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_address = 16'h0100; cpu_wdata = 8'h77;
    @(negedge clock);
    chk("abort_ram_we_before", {31'd0, ram_we}, 32'd1);
    chk("abort_ram_address", {16'd0, ram_address}, 32'h0100);
    reset = 1'b1;
    #1;
    chk("abort_outputs", {ram_address, ram_data_in, ram_we, dsp_ack, cpu_ack, owner, 3'd0},
        32'd0);
    chk("abort_rdata", {16'd0, dsp_rdata, cpu_rdata}, 32'd0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("abort_mem_unchanged", {24'd0, mem[16'h0100]}, 32'h11);

    // Restart from IDLE after reset
    txn(1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5);
    txn(1'b1, 1'b0, 16'h0003, 8'h00, 8'h43);
    txn(1'b1, 1'b0, 16'h0100, 8'h00, 8'h11);

    repeat (2) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
